// File: rtl/z80_mem_responder_pkg.sv
// Shared types and constants for the z80 bus memory responder.
// Imported by the interface-facing top and its RAM sub-module.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        HOLD
    } resp_state_t;

    localparam int WAIT_CNT_W = 4;

    // Keeps only the address bits above a DEPTH-byte window, so that
    // (addr & window_mask(DEPTH)) == BASE_ADDR selects the window.
    function automatic logic [15:0] window_mask(input int depth);
        logic [15:0] low_bits;
        low_bits = 16'(depth - 1);
        return ~low_bits;
    endfunction

endpackage

// File: rtl/z80_mem_responder_if.sv
// CPU bus as seen between a z80 master and a memory responder.
// Strobes are active-low; data_out/data_oe are merged onto data_bus by the system top.
interface z80_mem_responder_if;

    logic [15:0] addr_bus;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        MREQ_L;
    logic        IORQ_L;
    logic        RD_L;
    logic        WR_L;
    logic        M1_L;
    logic        RFSH_L;
    logic        WAIT_L;

    modport master (
        output addr_bus,
        output data_in,
        output MREQ_L,
        output IORQ_L,
        output RD_L,
        output WR_L,
        output M1_L,
        output RFSH_L,
        input  data_out,
        input  data_oe,
        input  WAIT_L
    );

    modport slave (
        input  addr_bus,
        input  data_in,
        input  MREQ_L,
        input  IORQ_L,
        input  RD_L,
        input  WR_L,
        input  M1_L,
        input  RFSH_L,
        output data_out,
        output data_oe,
        output WAIT_L
    );

endinterface

// File: rtl/z80_sync_ram.sv
// Byte RAM with registered read. The bus write port has priority over the
// preload port when both target the same offset in the same cycle.
module z80_sync_ram #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          bus_we,
    input  logic          bus_re,
    input  logic [AW-1:0] bus_addr,
    input  logic [7:0]    bus_wdata,
    output logic [7:0]    bus_rdata,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [7:0]    init_data
);

    logic [7:0] mem [DEPTH];
    logic       init_blocked;

    assign init_blocked = bus_we && (init_addr == bus_addr);

    always_ff @(posedge clk) begin
        if (init_we && !init_blocked) begin
            mem[init_addr] <= init_data;
        end
        if (bus_we) begin
            mem[bus_addr] <= bus_wdata;
        end
        // Read-before-write; the read register holds between accesses.
        if (bus_re) begin
            bus_rdata <= mem[bus_addr];
        end
    end

endmodule

// File: rtl/z80_mem_responder.sv
// Memory responder for the z80 CPU bus: decodes MREQ cycles into a RAM
// window, inserts WAIT_STATES wait cycles and drives read data via data_oe.
module z80_mem_responder
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH       = 16384,
    parameter int          WAIT_STATES = 1
) (
    input  logic                     clk,
    input  logic                     rst_L,
    z80_mem_responder_if.slave       bus,
    input  logic                     init_we,
    input  logic [$clog2(DEPTH)-1:0] init_addr,
    input  logic [7:0]               init_data,
    output logic                     proto_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [15:0] WIN_MASK = window_mask(DEPTH);

    resp_state_t           state_reg;
    logic [WAIT_CNT_W-1:0] cnt_reg;
    logic [AW-1:0]         offset_reg;
    logic                  is_write_reg;
    logic                  wait_l_reg;
    logic                  data_oe_reg;
    logic                  proto_err_reg;

    logic                  sel;
    logic                  strobe_hi;
    logic                  ram_we;
    logic                  ram_re;
    logic [7:0]            ram_rdata;

    // Refresh and I/O cycles also carry MREQ_L/addresses, so both are excluded.
    assign sel = !bus.MREQ_L && bus.IORQ_L && bus.RFSH_L &&
                 ((bus.addr_bus & WIN_MASK) == BASE_ADDR);

    // The strobe that started the current access, as latched in IDLE.
    assign strobe_hi = is_write_reg ? bus.WR_L : bus.RD_L;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            offset_reg    <= '0;
            is_write_reg  <= 1'b0;
            wait_l_reg    <= 1'b1;
            data_oe_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel && !bus.RD_L && !bus.WR_L) begin
                        proto_err_reg <= 1'b1;
                    end else if (sel && (!bus.RD_L || !bus.WR_L)) begin
                        offset_reg   <= bus.addr_bus[AW-1:0];
                        is_write_reg <= !bus.WR_L;
                        if (WAIT_STATES == 0) begin
                            state_reg <= ACCESS;
                        end else begin
                            state_reg  <= WAIT;
                            cnt_reg    <= WAIT_CNT_W'(WAIT_STATES);
                            wait_l_reg <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - WAIT_CNT_W'(1);
                    // A CPU that gives up mid-wait gets no access at all.
                    if (strobe_hi || bus.MREQ_L) begin
                        state_reg  <= IDLE;
                        wait_l_reg <= 1'b1;
                    end else if (cnt_reg == WAIT_CNT_W'(1)) begin
                        state_reg  <= ACCESS;
                        wait_l_reg <= 1'b1;
                    end
                end
                ACCESS: begin
                    state_reg <= HOLD;
                    if (!is_write_reg) begin
                        data_oe_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    // No re-decode here: one strobe assertion is one access.
                    if (strobe_hi && bus.MREQ_L) begin
                        state_reg   <= IDLE;
                        data_oe_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ram_we = (state_reg == ACCESS) && is_write_reg;
    assign ram_re = (state_reg == ACCESS) && !is_write_reg;

    z80_sync_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .bus_we    (ram_we),
        .bus_re    (ram_re),
        .bus_addr  (offset_reg),
        .bus_wdata (bus.data_in),
        .bus_rdata (ram_rdata),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    assign bus.WAIT_L   = wait_l_reg;
    assign bus.data_oe  = data_oe_reg;
    assign bus.data_out = data_oe_reg ? ram_rdata : 8'h00;
    assign proto_err    = proto_err_reg;

endmodule

// File: tb/tb_z80_mem_responder.sv
// Bench for z80_mem_responder: two instances (W=1/16K and W=3/4K) share one
// CPU bus stimulus; each is checked against a timeline model of the bus rules.
module tb_z80_mem_responder;

    localparam int D0 = 16384;
    localparam int D1 = 4096;
    localparam int W0 = 1;
    localparam int W1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_L;
    logic [15:0] addr_bus;
    logic [7:0]  data_in;
    logic        mreq_l, iorq_l, rd_l, wr_l, m1_l, rfsh_l;
    logic        init_we0, init_we1;
    logic [13:0] init_addr0;
    logic [11:0] init_addr1;
    logic [7:0]  init_data0, init_data1;
    logic        proto_err0, proto_err1;

    z80_mem_responder_if bi0();
    z80_mem_responder_if bi1();

    assign bi0.addr_bus = addr_bus;
    assign bi0.data_in  = data_in;
    assign bi0.MREQ_L   = mreq_l;
    assign bi0.IORQ_L   = iorq_l;
    assign bi0.RD_L     = rd_l;
    assign bi0.WR_L     = wr_l;
    assign bi0.M1_L     = m1_l;
    assign bi0.RFSH_L   = rfsh_l;
    assign bi1.addr_bus = addr_bus;
    assign bi1.data_in  = data_in;
    assign bi1.MREQ_L   = mreq_l;
    assign bi1.IORQ_L   = iorq_l;
    assign bi1.RD_L     = rd_l;
    assign bi1.WR_L     = wr_l;
    assign bi1.M1_L     = m1_l;
    assign bi1.RFSH_L   = rfsh_l;

    z80_mem_responder #(.BASE_ADDR(16'h0000), .DEPTH(D0), .WAIT_STATES(W0)) dut0 (
        .clk       (clk),
        .rst_L     (rst_L),
        .bus       (bi0),
        .init_we   (init_we0),
        .init_addr (init_addr0),
        .init_data (init_data0),
        .proto_err (proto_err0)
    );

    z80_mem_responder #(.BASE_ADDR(16'h0000), .DEPTH(D1), .WAIT_STATES(W1)) dut1 (
        .clk       (clk),
        .rst_L     (rst_L),
        .bus       (bi1),
        .init_we   (init_we1),
        .init_addr (init_addr1),
        .init_data (init_data1),
        .proto_err (proto_err1)
    );

    int errors = 0;
    int checks = 0;

    // Reference memory contents per instance.
    bit [7:0] m0 [D0];
    bit [7:0] m1 [D1];

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [7:0]  wdata;
        int          rel;
        bit          io;
        bit          rf;
        bit          sel0;
        bit          sel1;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
    } vec_t;

    vec_t vecs [12];

    function automatic logic get_wl(input int d);
        return (d == 0) ? bi0.WAIT_L : bi1.WAIT_L;
    endfunction
    function automatic logic get_oe(input int d);
        return (d == 0) ? bi0.data_oe : bi1.data_oe;
    endfunction
    function automatic logic [7:0] get_do(input int d);
        return (d == 0) ? bi0.data_out : bi1.data_out;
    endfunction
    function automatic logic get_pe(input int d);
        return (d == 0) ? proto_err0 : proto_err1;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mreq_l = 1'b1; iorq_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1; m1_l = 1'b1; rfsh_l = 1'b1;
    endtask

    task automatic preload(input bit we0, input bit we1, input int off, input logic [7:0] v0, input logic [7:0] v1);
        init_we0 = we0; init_addr0 = 14'(off); init_data0 = v0;
        init_we1 = we1; init_addr1 = 12'(off); init_data1 = v1;
        if (we0) m0[off % D0] = v0;
        if (we1) m1[off % D1] = v1;
        tick();
        init_we0 = 1'b0;
        init_we1 = 1'b0;
    endtask

    // One CPU cycle: strobes low in cycles 0..rel-1, checked every cycle
    // against the latency rules (wait low 1..W, oe from W+2 through release).
    task automatic run_txn(input string name, input logic [15:0] addr, input bit wr,
                           input logic [7:0] wdata, input int rel, input bit io, input bit rf,
                           input bit sel0, input bit sel1, input logic [7:0] rd0,
                           input logic [7:0] rd1, input bit collide, input logic [7:0] cdata);
        int         t;
        int         ws [2];
        bit         sl [2];
        bit         full [2];
        logic [7:0] rd [2];
        ws[0] = W0; ws[1] = W1;
        sl[0] = sel0; sl[1] = sel1;
        rd[0] = rd0; rd[1] = rd1;
        t = ((rel > 5) ? rel : 5) + 3;
        for (int d = 0; d < 2; d++) full[d] = sl[d] && (rel >= ws[d] + 1);
        for (int k = 0; k < t; k++) begin
            bit act;
            act = (k < rel);
            addr_bus = addr;
            data_in  = wdata;
            mreq_l   = !act;
            rd_l     = !(act && !wr);
            wr_l     = !(act && wr);
            m1_l     = !(act && !wr);
            iorq_l   = !(act && io);
            rfsh_l   = !(act && rf);
            init_we0 = collide && (k == W0 + 1); init_addr0 = addr[13:0]; init_data0 = cdata;
            init_we1 = collide && (k == W1 + 1); init_addr1 = addr[11:0]; init_data1 = cdata;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int   last;
                int   oe_end;
                logic wl_exp;
                logic oe_exp;
                last   = full[d] ? ws[d] : rel;
                oe_end = (rel > ws[d] + 2) ? rel : ws[d] + 2;
                wl_exp = !(sl[d] && k >= 1 && k <= last);
                oe_exp = full[d] && !wr && k >= ws[d] + 2 && k <= oe_end;
                chk($sformatf("%s dut%0d cyc%0d WAIT_L", name, d, k), 16'(get_wl(d)), 16'(wl_exp));
                chk($sformatf("%s dut%0d cyc%0d data_oe", name, d, k), 16'(get_oe(d)), 16'(oe_exp));
                if (oe_exp)
                    chk($sformatf("%s dut%0d cyc%0d data_out", name, d, k), 16'(get_do(d)), 16'(rd[d]));
            end
            tick();
        end
        init_we0 = 1'b0;
        init_we1 = 1'b0;
        bus_idle();
        if (full[0] && wr) m0[addr % D0] = wdata;
        if (full[1] && wr) m1[addr % D1] = wdata;
        $display("txn %s addr=%04h %s rel=%0d io=%0d rf=%0d sel=%0d/%0d", name, addr,
                 wr ? "WR" : "RD", rel, io, rf, sel0, sel1);
    endtask

    // Bus contention: data_oe may outlast RD_L by at most one cycle.
    initial begin
        int hi_cnt [2];
        hi_cnt[0] = 0;
        hi_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_L !== 1'b1) begin
                    hi_cnt[d] = 0;
                end else begin
                    if (get_oe(d) === 1'b1 && rd_l === 1'b1) hi_cnt[d]++;
                    else hi_cnt[d] = 0;
                    checks++;
                    if (hi_cnt[d] > 1) begin
                        errors++;
                        $display("FAIL contention dut%0d: data_oe high with RD_L high for %0d cycles, limit 1",
                                 d, hi_cnt[d]);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        bit          wr, io, rf;
        int          rel, p;
        logic [7:0]  wd;

        vecs[0]  = '{16'h0010, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5};
        vecs[1]  = '{16'h0200, 1'b1, 8'h3C, 6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[2]  = '{16'h0200, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C};
        vecs[3]  = '{16'h4000, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[4]  = '{16'h0010, 1'b0, 8'h00, 6, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{16'h0010, 1'b0, 8'h00, 6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{16'h1010, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00};
        vecs[7]  = '{16'h0010, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5};
        vecs[8]  = '{16'h0020, 1'b1, 8'h77, 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[9]  = '{16'h0020, 1'b0, 8'h00, 5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'hE3};
        vecs[10] = '{16'h0021, 1'b1, 8'h12, 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[11] = '{16'h0021, 1'b0, 8'h00, 7, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'hE2};

        rst_L = 1'b0;
        addr_bus = 16'h0000;
        data_in = 8'h00;
        bus_idle();
        init_we0 = 1'b0; init_we1 = 1'b0;
        init_addr0 = '0; init_addr1 = '0;
        init_data0 = 8'h00; init_data1 = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset dut%0d WAIT_L", d), 16'(get_wl(d)), 16'h1);
            chk($sformatf("reset dut%0d data_oe", d), 16'(get_oe(d)), 16'h0);
            chk($sformatf("reset dut%0d data_out", d), 16'(get_do(d)), 16'h00);
            chk($sformatf("reset dut%0d proto_err", d), 16'(get_pe(d)), 16'h0);
        end
        tick();
        rst_L = 1'b1;
        tick();

        for (int o = 0; o < 64; o++) preload(1'b1, 1'b1, o, 8'(o * 3 + 1), 8'(o) ^ 8'hC3);
        preload(1'b1, 1'b1, 16'h0010, 8'hA5, 8'hA5);
        preload(1'b1, 1'b0, 16'h1010, 8'h5A, 8'h00);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rel,
                    vecs[i].io, vecs[i].rf, vecs[i].sel0, vecs[i].sel1, vecs[i].rd0, vecs[i].rd1,
                    1'b0, 8'h00);
        end

        // Bus write and preload hit offset 5 in the same (ACCESS) cycle.
        run_txn("collide_wr", 16'h0005, 1'b1, 8'h11, 6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h22);
        run_txn("collide_rd", 16'h0005, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h11, 1'b0, 8'h00);

        // Both strobes low on a selected cycle.
        addr_bus = 16'h0001;
        mreq_l = 1'b0; rd_l = 1'b0; wr_l = 1'b0; data_in = 8'hEE;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("proto dut%0d cyc%0d WAIT_L", d, k), 16'(get_wl(d)), 16'h1);
                chk($sformatf("proto dut%0d cyc%0d data_oe", d, k), 16'(get_oe(d)), 16'h0);
            end
            tick();
        end
        bus_idle();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) chk($sformatf("proto dut%0d proto_err set", d), 16'(get_pe(d)), 16'h1);
        run_txn("proto_rd", 16'h0001, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b1, m0[1], m1[1], 1'b0, 8'h00);
        for (int d = 0; d < 2; d++) chk($sformatf("proto dut%0d proto_err sticky", d), 16'(get_pe(d)), 16'h1);
        rst_L = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("proto dut%0d proto_err reset", d), 16'(get_pe(d)), 16'h0);
        tick();
        rst_L = 1'b1;
        tick();
        $display("txn proto_err sequence addr=0001");

        // Reset asserted while both instances are stretching a write.
        addr_bus = 16'h0030; data_in = 8'h99;
        mreq_l = 1'b0; wr_l = 1'b0;
        tick();
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("rstwait dut%0d WAIT_L before", d), 16'(get_wl(d)), 16'h0);
        rst_L = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rstwait dut%0d WAIT_L async", d), 16'(get_wl(d)), 16'h1);
            chk($sformatf("rstwait dut%0d data_oe async", d), 16'(get_oe(d)), 16'h0);
        end
        tick();
        bus_idle();
        tick();
        rst_L = 1'b1;
        tick();
        $display("txn reset-in-wait addr=0030 WR");
        run_txn("rstwait_rd", 16'h0030, 1'b0, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b1, m0[16'h30], m1[16'h30], 1'b0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(0, 9);
            if (p < 8) a = 16'($urandom_range(0, 63));
            else if (p == 8) a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
            else a = 16'h1010;
            wr  = 1'($urandom_range(0, 1));
            wd  = 8'($urandom);
            rel = $urandom_range(1, 7);
            io  = ($urandom_range(0, 7) == 0);
            rf  = !io && ($urandom_range(0, 7) == 0);
            run_txn($sformatf("rnd%0d", i), a, wr, wd, rel, io, rf,
                    !io && !rf && (a < D0), !io && !rf && (a < D1),
                    m0[a % D0], m1[a % D1], 1'b0, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
